// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register file: clear-FSM states, default
// widths and the zero-register test.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } regfile_state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  function automatic logic is_zero_reg(input logic [31:0] addr, input int zero_reg);
    return (zero_reg != 0) && (addr == 32'd0);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port of the register file. The output is forced to zero
// while the clear runs and for the hardwired zero register. A write hit
// selects the incoming write data instead of the array contents.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  force_zero,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  wr_hit,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Next read value: zero-forcing has priority over the bypass mux.
  always_comb begin
    rd_data_d = '0;
    if (reset || force_zero) begin
      rd_data_d = '0;
    end else if (is_zero_reg(32'(rd_addr), ZERO_REG)) begin
      rd_data_d = '0;
    end else if (wr_hit) begin
      rd_data_d = wr_data;
    end else begin
      rd_data_d = mem_data;
    end
  end

  // Read data register.
  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/register_file.sv
// Parametrised 2-read/1-write register file with a sequential post-reset clear.
// Optional feature: define REGFILE_BYPASS_EN for write-first read forwarding.
module register_file
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  busy,
  input  logic [ADDR_WIDTH-1:0] rdAddrA,
  output logic [DATA_WIDTH-1:0] rdDataA,
  input  logic [ADDR_WIDTH-1:0] rdAddrB,
  output logic [DATA_WIDTH-1:0] rdDataB,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0] wrData,
  input  logic                  wrEnable
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  regfile_state_e        state_d, state_q;
  logic [ADDR_WIDTH-1:0] clr_ptr_d, clr_ptr_q;
  logic                  busy_d, busy_q;

  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_waddr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;
  logic                  wr_accept_s;
  logic                  hit_a_s, hit_b_s;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // FSM state register.
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_ptr_q <= clr_ptr_d;
    busy_q    <= busy_d;
  end

  // FSM next state: walk the clear pointer once, then stay READY until reset.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (reset) begin
      state_d   = CLEAR;
      clr_ptr_d = '0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr_ptr_q == LAST_IDX) begin
            state_d = READY;
          end else begin
            clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
          end
        end
        READY:   state_d = READY;
        default: begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      endcase
    end
  end

  // FSM outputs: busy flag and the single array write port.
  always_comb begin
    busy_d      = (state_d == CLEAR);
    wr_accept_s = 1'b0;
    mem_we_s    = 1'b0;
    mem_waddr_s = clr_ptr_q;
    mem_wdata_s = '0;
    if (reset) begin
      busy_d = 1'b1;
    end else if (state_q == CLEAR) begin
      mem_we_s = 1'b1;
    end else begin
      wr_accept_s = wrEnable && !is_zero_reg(32'(wrAddr), ZERO_REG);
      mem_we_s    = wr_accept_s;
      mem_waddr_s = wrAddr;
      mem_wdata_s = wrData;
    end
  end

  // Storage array: no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign hit_a_s = wr_accept_s && (wrAddr == rdAddrA);
  assign hit_b_s = wr_accept_s && (wrAddr == rdAddrB);
`else
  assign hit_a_s = 1'b0;
  assign hit_b_s = 1'b0;
`endif

  regfile_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_port_a (
    .clk       (clk),
    .reset     (reset),
    .force_zero(state_q == CLEAR),
    .rd_addr   (rdAddrA),
    .mem_data  (mem_q[rdAddrA]),
    .wr_hit    (hit_a_s),
    .wr_data   (wrData),
    .rd_data   (rdDataA)
  );

  regfile_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_port_b (
    .clk       (clk),
    .reset     (reset),
    .force_zero(state_q == CLEAR),
    .rd_addr   (rdAddrB),
    .mem_data  (mem_q[rdAddrB]),
    .wr_hit    (hit_b_s),
    .wr_data   (wrData),
    .rd_data   (rdDataB)
  );

  assign busy = busy_q;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: one ZERO_REG=1 and one ZERO_REG=0 instance
// share all inputs; expectations are hand-computed.
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [31:0] wr_data;
  logic        wr_enable;
  logic        busy1, busy2;
  logic [31:0] rd_a1, rd_b1, rd_a2, rd_b2;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .busy(busy1),
    .rdAddrA(rd_addr_a), .rdDataA(rd_a1),
    .rdAddrB(rd_addr_b), .rdDataB(rd_b1),
    .wrAddr(wr_addr), .wrData(wr_data), .wrEnable(wr_enable)
  );

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ZERO_REG(0)) dut_nz (
    .clk(clk), .reset(reset), .busy(busy2),
    .rdAddrA(rd_addr_a), .rdDataA(rd_a2),
    .rdAddrB(rd_addr_b), .rdDataB(rd_b2),
    .wrAddr(wr_addr), .wrData(wr_data), .wrEnable(wr_enable)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges 1..16 after reset release: busy high through edge 15, low after 16.
  task automatic check_clear(input string tag);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check({tag, "_busy"}, {31'd0, busy1}, (i < 16) ? 32'd1 : 32'd0);
      check({tag, "_busy_nz"}, {31'd0, busy2}, (i < 16) ? 32'd1 : 32'd0);
      if (i < 16) check({tag, "_rd_during_clear"}, rd_a1, 32'd0);
    end
  endtask

  task automatic write(input logic [3:0] a, input logic [31:0] d);
    wr_addr = a; wr_data = d; wr_enable = 1'b1;
    tick();
    wr_enable = 1'b0;
  endtask

  task automatic read(input logic [3:0] a, input logic [3:0] b);
    rd_addr_a = a; rd_addr_b = b;
    tick();
  endtask

  initial begin
    reset = 1'b1; rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    wr_addr = 4'd0; wr_data = 32'd0; wr_enable = 1'b0;

    // Reset then idle
    tick(); tick();
    check("reset_busy", {31'd0, busy1}, 32'd1);
    check("reset_rdA", rd_a1, 32'd0);
    check("reset_rdB", rd_b1, 32'd0);
    reset = 1'b0;
    check_clear("clear1");
    for (int a = 0; a < 16; a++) begin
      read(4'(a), 4'(15 - a));
      check("idle_rdA", rd_a1, 32'd0);
      check("idle_rdB", rd_b1, 32'd0);
      check("idle_rdA_nz", rd_a2, 32'd0);
      check("idle_rdB_nz", rd_b2, 32'd0);
    end

    // Write then read
    write(4'd5, 32'hDEADBEEF);
    read(4'd5, 4'd5);
    check("r5_A", rd_a1, 32'hDEADBEEF);
    check("r5_B", rd_b1, 32'hDEADBEEF);

    // Zero register
    write(4'd0, 32'h12345678);
    read(4'd0, 4'd5);
    check("r0_zero", rd_a1, 32'd0);
    check("r0_nz", rd_a2, 32'h12345678);
    check("r5_B_again", rd_b1, 32'hDEADBEEF);

    // Same-cycle hazard
    write(4'd7, 32'h1);
    rd_addr_a = 4'd7; rd_addr_b = 4'd7;
    write(4'd7, 32'h2);
`ifdef REGFILE_BYPASS_EN
    check("hazard_A", rd_a1, 32'h2);
    check("hazard_B", rd_b1, 32'h2);
`else
    check("hazard_A", rd_a1, 32'h1);
    check("hazard_B", rd_b1, 32'h1);
`endif
    tick();
    check("r7_after", rd_a1, 32'h2);
    check("r7_after_nz", rd_b2, 32'h2);

    // Bypassed write to r0 must still read zero on the ZERO_REG=1 instance
    rd_addr_a = 4'd0;
    write(4'd0, 32'h55);
`ifdef REGFILE_BYPASS_EN
    check("r0_bypass_nz", rd_a2, 32'h55);
`else
    check("r0_bypass_nz", rd_a2, 32'h12345678);
`endif
    check("r0_bypass", rd_a1, 32'd0);

    // Write during busy: dropped at clear cycles 4 and 10
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      wr_enable = (i == 4) || (i == 10);
      wr_addr = 4'd3; wr_data = 32'hAAAA5555;
      tick();
      check("busy_wr_busy", {31'd0, busy1}, (i < 16) ? 32'd1 : 32'd0);
    end
    wr_enable = 1'b0;
    read(4'd3, 4'd5);
    check("r3_dropped", rd_a1, 32'd0);
    check("r3_dropped_nz", rd_a2, 32'd0);
    check("r5_cleared", rd_b1, 32'd0);

    // Reset mid-clear
    write(4'd9, 32'hCAFEF00D);
    read(4'd9, 4'd9);
    check("r9_written", rd_a1, 32'hCAFEF00D);
    reset = 1'b1; tick(); reset = 1'b0;
    check("reset_clears_rd", rd_a1, 32'd0);
    for (int i = 1; i <= 7; i++) tick();
    check("midclear_busy", {31'd0, busy1}, 32'd1);
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    check("rereset_busy", {31'd0, busy1}, 32'd1);
    check_clear("clear2");
    read(4'd9, 4'd9);
    check("r9_cleared", rd_a1, 32'd0);
    check("r9_cleared_nz", rd_b2, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
